// File: rtl/sram_rr_arbiter_if.sv
// Request/response bundle for the two requesters (A and B) of the SRAM arbiter.
// A request transfers on a rising edge where valid && ready; ready is a same-cycle function of both valids; rvalid is a one-cycle pulse with no backpressure.
interface sram_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  a_valid;
    logic                  a_ready;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_valid;
    logic                  b_ready;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rvalid, b_rdata
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rvalid, b_rdata
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one single-port OpenRAM macro.
// Optionally zero-fills the array after reset; read data returns two cycles after the grant.
module sram_rr_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk0,
    input  logic                  resetb,
    sram_rr_arbiter_if.slave      req,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done,
    output logic                  dbg_state
);
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic                  PORT_A      = 1'b0;
    localparam logic                  PORT_B      = 1'b1;
    localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [1:0]            rd_v_q, rd_v_d;
    logic [1:0]            rd_port_q, rd_port_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  a_ready, b_ready, run_en;

    // Gated by resetb so nothing is offered or reported done while reset is held.
    assign run_en = (state_q == ST_RUN) && resetb;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_cnt_d  = clr_cnt_q;
        csb_d      = 1'b1;
        web_d      = 1'b1;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_v_d     = {rd_v_q[0], 1'b0};
        rd_port_d  = {rd_port_q[0], 1'b0};
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        a_rvalid_d = rd_v_q[1] && (rd_port_q[1] == PORT_A);
        b_rvalid_d = rd_v_q[1] && (rd_port_q[1] == PORT_B);
        a_rdata_d  = a_rvalid_d ? sram_dout0 : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? sram_dout0 : b_rdata_q;

        case (state_q)
            ST_CLEAR: begin
                csb_d     = 1'b0;
                web_d     = 1'b0;
                addr_d    = clr_cnt_q;
                din_d     = '0;
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_ready = run_en && req.a_valid && (!req.b_valid || ptr_q == PORT_B);
                b_ready = run_en && req.b_valid && (!req.a_valid || ptr_q == PORT_A);
                if (a_ready) begin
                    csb_d        = 1'b0;
                    web_d        = !req.a_we;
                    addr_d       = req.a_addr;
                    ptr_d        = PORT_A;
                    rd_v_d[0]    = !req.a_we;
                    rd_port_d[0] = PORT_A;
                    if (req.a_we) begin
                        din_d = req.a_wdata;
                    end
                end else if (b_ready) begin
                    csb_d        = 1'b0;
                    web_d        = !req.b_we;
                    addr_d       = req.b_addr;
                    ptr_d        = PORT_B;
                    rd_v_d[0]    = !req.b_we;
                    rd_port_d[0] = PORT_B;
                    if (req.b_we) begin
                        din_d = req.b_wdata;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!resetb) begin
            state_q    <= RESET_STATE;
            ptr_q      <= PORT_B;
            clr_cnt_q  <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            rd_v_q     <= '0;
            rd_port_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_cnt_q  <= clr_cnt_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_v_q     <= rd_v_d;
            rd_port_q  <= rd_port_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign req.a_ready  = a_ready;
    assign req.b_ready  = b_ready;
    assign req.a_rvalid = a_rvalid_q;
    assign req.b_rvalid = b_rvalid_q;
    assign req.a_rdata  = a_rdata_q;
    assign req.b_rdata  = b_rdata_q;

    assign sram_csb0  = csb_q;
    assign sram_web0  = web_q;
    assign sram_addr0 = addr_q;
    assign sram_din0  = din_q;
    assign init_done  = run_en;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: behavioural SRAM macro, reference memory/arbiter model and a read-data scoreboard.
module tb_sram_rr_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk0 = 1'b0;
    logic resetb;
    logic resetb2;
    always #5 clk0 = ~clk0;

    sram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq ();
    sram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq2 ();

    logic          sram_csb0, sram_web0, init_done, dbg_state;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0, sram_dout0;
    logic          csb2, web2, init_done2, dbg_state2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] din2;
    logic [DW-1:0] dout2 = '0;

    sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk0(clk0), .resetb(resetb), .req(rq),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .init_done(init_done), .dbg_state(dbg_state)
    );

    sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk0(clk0), .resetb(resetb2), .req(rq2),
        .sram_csb0(csb2), .sram_web0(web2), .sram_addr0(addr2),
        .sram_din0(din2), .sram_dout0(dout2),
        .init_done(init_done2), .dbg_state(dbg_state2)
    );

    // Macro model: pins captured at the rising edge, array accessed at the following falling edge.
    logic [DW-1:0] mem [DEPTH];
    logic          s_csb = 1'b1;
    logic          s_web = 1'b1;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;

    always @(posedge clk0) begin
        s_csb  <= sram_csb0;
        s_web  <= sram_web0;
        s_addr <= sram_addr0;
        s_din  <= sram_din0;
    end

    always @(negedge clk0) begin
        if (!s_csb) begin
            if (!s_web) mem[s_addr] = s_din;
            else        sram_dout0 = mem[s_addr];
        end
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          last_grant;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input logic port, input logic [DW-1:0] data);
        logic [DW:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected port=%0d actual=rvalid expected=none t=%0t", port, $time);
        end else begin
            e = exp_q.pop_front();
            check("rd_port", port, e[DW]);
            check("rd_data", data, e[DW-1:0]);
        end
    endtask

    always @(negedge clk0) begin
        check("rvalid_excl", rq.a_rvalid & rq.b_rvalid, 0);
        if (rq.a_rvalid === 1'b1) pop_check(1'b0, rq.a_rdata);
        if (rq.b_rvalid === 1'b1) pop_check(1'b1, rq.b_rdata);
    end

    task automatic ref_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_grant = 1'b1;
    endtask

    // One bus cycle: drive at a falling edge, predict the winner, update the model, advance.
    task automatic cycle(input logic av, input logic awe, input logic [AW-1:0] aaddr, input logic [DW-1:0] awd,
                         input logic bv, input logic bwe, input logic [AW-1:0] baddr, input logic [DW-1:0] bwd);
        logic          win_valid, win, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        rq.a_valid = av; rq.a_we = awe; rq.a_addr = aaddr; rq.a_wdata = awd;
        rq.b_valid = bv; rq.b_we = bwe; rq.b_addr = baddr; rq.b_wdata = bwd;
        #1;
        win_valid = av || bv;
        if (av && bv) win = ~last_grant;
        else          win = bv;
        check("a_ready", rq.a_ready, win_valid && !win);
        check("b_ready", rq.b_ready, win_valid && win);
        if (win_valid) begin
            we   = win ? bwe : awe;
            addr = win ? baddr : aaddr;
            wd   = win ? bwd : awd;
            if (we) ref_mem[addr] = wd;
            else    exp_q.push_back({win, ref_mem[addr]});
            last_grant = win;
        end
        @(negedge clk0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic random_traffic(input int n);
        logic [AW-1:0] aa, ba;
        for (int i = 0; i < n; i++) begin
            aa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
            ba = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ba, $urandom);
        end
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_csb0"}, sram_csb0, 1);
        check({tag, "_web0"}, sram_web0, 1);
        check({tag, "_addr0"}, sram_addr0, 0);
        check({tag, "_din0"}, sram_din0, 0);
        check({tag, "_rvalid"}, {rq.a_rvalid, rq.b_rvalid}, 0);
        check({tag, "_a_rdata"}, rq.a_rdata, 0);
        check({tag, "_b_rdata"}, rq.b_rdata, 0);
        check({tag, "_init_done"}, init_done, 0);
    endtask

    // Entered at the first falling edge after reset release; leaves at the edge where init_done rises.
    task automatic check_clear();
        for (int i = 0; i < DEPTH; i++) begin
            check("clear_pins", {sram_csb0, sram_web0, sram_din0, 22'(sram_addr0)}, {1'b0, 1'b0, 32'h0, 22'(i)});
            check("clear_init_done", init_done, (i == DEPTH-1));
            if (i != DEPTH-1) @(negedge clk0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        resetb = 1'b0;
        resetb2 = 1'b0;
        rq.a_valid = 0; rq.a_we = 0; rq.a_addr = '0; rq.a_wdata = '0;
        rq.b_valid = 0; rq.b_we = 0; rq.b_addr = '0; rq.b_wdata = '0;
        rq2.a_valid = 1; rq2.a_we = 0; rq2.a_addr = 10'h005; rq2.a_wdata = '0;
        rq2.b_valid = 0; rq2.b_we = 0; rq2.b_addr = '0; rq2.b_wdata = '0;
        repeat (3) @(negedge clk0);

        reset_values("rst");
        check("dut2_init_done_rst", init_done2, 0);
        check("dut2_ready_rst", rq2.a_ready, 0);
        ref_reset();

        resetb = 1'b1;
        resetb2 = 1'b1;
        #1;
        check("dut2_init_done_rel", init_done2, 1);
        check("dut2_ready_rel", rq2.a_ready, 1);
        @(negedge clk0);
        check("dut2_issue", {csb2, web2, addr2}, {1'b0, 1'b1, 10'h005});
        rq2.a_valid = 0;
        check_clear();

        // Cleared word, then write followed by read of the same address with latency probes.
        cycle(1, 0, 10'h3FF, '0, 0, 0, '0, '0);
        idle(3);
        cycle(1, 1, 10'h010, 32'hDEADBEEF, 0, 0, '0, '0);
        cycle(1, 0, 10'h010, '0, 0, 0, '0, '0);
        check("lat_edge0", rq.a_rvalid, 0);
        idle(1);
        check("lat_edge1", rq.a_rvalid, 0);
        idle(1);
        check("lat_edge2", {rq.a_rvalid, rq.b_rvalid, rq.a_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        idle(2);

        // B alone: three writes then three reads, then contention must favour A first.
        for (int k = 0; k < 3; k++) cycle(0, 0, '0, '0, 1, 1, AW'(k + 1), $urandom);
        for (int k = 0; k < 3; k++) cycle(0, 0, '0, '0, 1, 0, AW'(k + 1), '0);
        for (int k = 0; k < 6; k++) cycle(1, 0, 10'h001, '0, 1, 0, 10'h002, '0);
        idle(3);

        random_traffic(400);
        idle(3);

        // Reset one cycle after a read grant: the read must vanish and the clear must restart.
        cycle(1, 0, 10'h005, '0, 0, 0, '0, '0);
        resetb = 1'b0;
        exp_q.delete();
        @(negedge clk0);
        reset_values("midrst");
        @(negedge clk0);
        check("midrst_no_rvalid", {rq.a_rvalid, rq.b_rvalid}, 0);
        ref_reset();
        resetb = 1'b1;
        @(negedge clk0);
        check_clear();

        random_traffic(150);
        idle(4);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of one 32x1024 OpenRAM single-port RW SRAM macro (sky130).
- Accepts valid/ready read and write requests from requesters A and B, drives the macro's registered, active-low control pins, and returns read data to the requester that issued the read.
- Optionally zero-fills the whole array after reset before it accepts any traffic.

Parameters:
DATA_WIDTH, 32, SRAM word width
ADDR_WIDTH, 10, SRAM address width (depth = 2**ADDR_WIDTH)
CLEAR_ON_RESET, 1, 1 = write zero to every word after reset before accepting requests

Ports:
clk0  input  1  clock, shared with SRAM clk0
resetb  input  1  synchronous active-low reset
a_valid  input  1  requester A request valid
a_ready  output  1  requester A request accepted this cycle
a_we  input  1  1 = write, 0 = read
a_addr  input  ADDR_WIDTH  requester A word address
a_wdata  input  DATA_WIDTH  requester A write data
a_rvalid  output  1  requester A read data valid (1-cycle pulse)
a_rdata  output  DATA_WIDTH  requester A read data
b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata  same as A, for requester B
sram_csb0  output  1  SRAM chip select, active low, registered
sram_web0  output  1  SRAM write enable, active low, registered
sram_addr0  output  ADDR_WIDTH  SRAM address, registered
sram_din0  output  DATA_WIDTH  SRAM write data, registered
sram_dout0  input  DATA_WIDTH  SRAM read data
init_done  output  1  high once the array is ready for traffic

Behaviour:
- Clock and reset: single clock clk0, synchronous active-low reset resetb.
- Reset values: sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, a/b_rvalid=0, a/b_rdata=0, init_done=0, rr pointer = B (so A wins first contention), all pipeline valid bits = 0.
- Reset mid-operation: in-flight reads are dropped; no rvalid is produced for them. The clear sequence restarts from address 0.
- FSM states:
  - CLEAR (entered from reset when CLEAR_ON_RESET=1): each cycle registers csb0=0, web0=0, din0=0, addr0=counter; counter increments 0..2**ADDR_WIDTH-1. After the last address is issued, go to RUN.
  - RUN: entered directly from reset when CLEAR_ON_RESET=0.
  - init_done=1 and ready may assert only in RUN.
- Arbitration (RUN), combinational:
  - a_ready = a_valid && (!b_valid || ptr==B).
  - b_ready = b_valid && (!a_valid || ptr==A).
  - At most one ready per cycle. ready never asserts without its valid.
  - ptr updates to the granted port on grant and holds when there is no grant.
- Issue: on grant at posedge P0, register csb0=0, web0=!we, addr0, din0 (din0 = wdata for writes; don't-care for reads, hold previous value). With no grant: csb0=1, web0=1, other pins hold.
- SRAM timing: the macro samples at P1, updates/reads at the negedge, and sram_dout0 is stable before P2.
- Read return: a 2-stage shift of {valid, port-id} tracks each read. At P2, copy sram_dout0 into x_rdata of the issuing port and pulse x_rvalid for exactly one cycle.
  - Read latency: 2 cycles from the accepting edge.
  - Full throughput: one request per cycle, back-to-back reads pipelined.
  - No rvalid for writes. rdata holds its last value between pulses. No response backpressure: requesters must accept rvalid.
- Ordering: requests execute in grant order. A read granted the cycle after a write to the same address returns the new data.
- Continuous valid on both ports: grants alternate A,B,A,B,… with no idle cycles.

Test Plan:
- CLEAR_ON_RESET=1, release reset, no traffic -> init_done rises after exactly 1024 clear writes (counter 0..1023 observed on sram_addr0 with web0=0, din0=0); read of 0x3FF then returns 0x00000000.
- A writes 0xDEADBEEF @0x010, next cycle A reads 0x010 -> a_ready both cycles; a_rvalid pulses 2 cycles after the read grant with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- A and B both hold valid for 6 cycles, reads of 0x001/0x002 -> grants A,B,A,B,A,B; rvalid pulses alternate per port with the correct data, one per cycle.
- Only B valid, 3 back-to-back writes then 3 reads -> b_ready every cycle, ptr=B afterwards; the next contention grants A first.
- resetb asserted one cycle after a read grant -> no rvalid from either port; outputs return to reset values on the next edge; the clear sequence restarts at address 0.
- CLEAR_ON_RESET=0 -> init_done=1 and grants possible on the first cycle after reset release.
